// File: rtl/ula_arbiter.sv
// ula_arbiter
//   Two-requester round-robin front end for one shared combinational ULA.
//   The winning request's opcode/funct/operands are latched onto ula_*,
//   held for a per-operation settle time (longer for MULT/DIV), and the
//   ULA result is registered and returned with a one-cycle done pulse.
//
// Ports
//   clock, reset              rising-edge clock, synchronous active-high reset
//   req_x/op_x/funct_x/a_x/b_x requester x (x = 0,1) request and operands
//   gnt_x                     one-cycle pulse: requester x operands latched
//   done_x                    one-cycle pulse: res/zero valid for requester x
//   res, zero                 registered ULA Resultado / Zero
//   busy                      high outside IDLE
//   ula_opcode/funct/a/b      latched operands driving the ULA
//   ula_res, ula_zero         combinational ULA outputs
module ula_arbiter #(
  parameter int LAT_FAST = 1,
  parameter int LAT_SLOW = 4,
  parameter int CNT_W    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_0,
  input  logic [5:0]  op_0,
  input  logic [5:0]  funct_0,
  input  logic [31:0] a_0,
  input  logic [31:0] b_0,
  input  logic        req_1,
  input  logic [5:0]  op_1,
  input  logic [5:0]  funct_1,
  input  logic [31:0] a_1,
  input  logic [31:0] b_1,
  output logic        gnt_0,
  output logic        gnt_1,
  output logic        done_0,
  output logic        done_1,
  output logic [31:0] res,
  output logic        zero,
  output logic        busy,
  output logic [5:0]  ula_opcode,
  output logic [5:0]  ula_funct,
  output logic [31:0] ula_a,
  output logic [31:0] ula_b,
  input  logic [31:0] ula_res,
  input  logic        ula_zero
);

  localparam logic [CNT_W-1:0] CNT_FAST = CNT_W'(LAT_FAST);
  localparam logic [CNT_W-1:0] CNT_SLOW = CNT_W'(LAT_SLOW);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [1:0]          r_gnt;
  logic [1:0]          r_done;
  logic [31:0]         r_res;
  logic                r_zero;
  logic [5:0]          r_op;
  logic [5:0]          r_fn;
  logic [31:0]         r_a;
  logic [31:0]         r_b;
  logic                r_last;   // last-granted port
  logic                r_owner;  // port that owns the op in flight

  logic [1:0]          w_req;
  logic [1:0][5:0]     w_op;
  logic [1:0][5:0]     w_fn;
  logic [1:0][31:0]    w_a;
  logic [1:0][31:0]    w_b;
  logic                w_win;
  logic                w_slow;

  assign w_req = {req_1, req_0};
  assign w_op  = {op_1, op_0};
  assign w_fn  = {funct_1, funct_0};
  assign w_a   = {a_1, a_0};
  assign w_b   = {b_1, b_0};

  // On a tie the port opposite the last grant wins; otherwise the lone requester.
  assign w_win  = (w_req == 2'b11) ? ~r_last : w_req[1];

  // MULT/DIV: opcode 0 with funct 2 or 3.
  assign w_slow = (w_op[w_win] == 6'd0) && (w_fn[w_win][5:1] == 5'b00001);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_res   <= '0;
      r_zero  <= 1'b0;
      r_op    <= '0;
      r_fn    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (|w_req) begin
            r_op         <= w_op[w_win];
            r_fn         <= w_fn[w_win];
            r_a          <= w_a[w_win];
            r_b          <= w_b[w_win];
            r_gnt[w_win] <= 1'b1;
            r_last       <= w_win;
            r_owner      <= w_win;
            r_cnt        <= w_slow ? CNT_SLOW : CNT_FAST;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Counter holds the number of EXEC cycles still to run, this one included.
          if (r_cnt == CNT_ONE) begin
            r_res           <= ula_res;
            r_zero          <= ula_zero;
            r_done[r_owner] <= 1'b1;
            r_cnt           <= '0;
            r_state         <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt_0      = r_gnt[0];
  assign gnt_1      = r_gnt[1];
  assign done_0     = r_done[0];
  assign done_1     = r_done[1];
  assign res        = r_res;
  assign zero       = r_zero;
  assign busy       = (r_state != S_IDLE);
  assign ula_opcode = r_op;
  assign ula_funct  = r_fn;
  assign ula_a      = r_a;
  assign ula_b      = r_b;

endmodule

// File: doc/ula_arbiter.md
Name: ula_arbiter

Overview:
- Two-requester round-robin scheduler that shares one combinational ULA instance.
- Typical requesters: main datapath (port 0) and address/branch helper (port 1).
- Latches the winner's opcode, funct and operands, drives the ULA for a per-operation settle time, registers Resultado/Zero, and returns them with a one-cycle done pulse.
- The settle time is longer for MULT/DIV (opcode 0, funct 2/3), so the multiplier/divider paths can be multicycle-constrained.

Parameters:
LAT_FAST, 1, EXEC cycles for every op except MULT/DIV; legal range 1..2^CNT_W-1.
LAT_SLOW, 4, EXEC cycles for opcode 6'b000000 with funct 6'b000010 or 6'b000011; legal range 1..2^CNT_W-1.
CNT_W, 4, width of the settle counter.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
req_0  in  1  requester 0 request; held until gnt_0.
op_0  in  6  requester 0 Opcode.
funct_0  in  6  requester 0 funct.
a_0  in  32  requester 0 Dados_1.
b_0  in  32  requester 0 Dados_2.
req_1  in  1  requester 1 request.
op_1  in  6  requester 1 Opcode.
funct_1  in  6  requester 1 funct.
a_1  in  32  requester 1 Dados_1.
b_1  in  32  requester 1 Dados_2.
gnt_0  out  1  one-cycle pulse: requester 0 operands latched.
gnt_1  out  1  one-cycle pulse: requester 1 operands latched.
done_0  out  1  one-cycle pulse: res/zero valid for requester 0.
done_1  out  1  one-cycle pulse: res/zero valid for requester 1.
res  out  32  registered ULA Resultado.
zero  out  1  registered ULA Zero.
busy  out  1  high whenever state is not IDLE.
ula_opcode  out  6  to ULA Opcode.
ula_funct  out  6  to ULA funct.
ula_a  out  32  to ULA Dados_1.
ula_b  out  32  to ULA Dados_2.
ula_res  in  32  from ULA Resultado.
ula_zero  in  1  from ULA Zero.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; the settle counter clears.
  - All outputs go to 0: gnt_*, done_*, res, zero, busy, ula_*.
  - The last-granted pointer goes to 1, so port 0 wins the first tie.
  - Reset has priority over every other event.
- States: IDLE, EXEC, DONE.
- IDLE:
  - req_* is sampled only in IDLE.
  - If only one req is high, that port wins.
  - If both are high, the port opposite the last-granted pointer wins.
  - On the winning edge:
    - Latch op/funct/a/b into the ula_* registers.
    - Set gnt_x=1 for exactly one cycle.
    - Update the pointer and record the owner.
    - Load the counter with LAT_SLOW for MULT/DIV, else LAT_FAST.
    - Go to EXEC.
  - With no req, stay in IDLE; ula_* hold their last values.
- EXEC:
  - ula_* stay stable.
  - The counter decrements each cycle.
  - On the edge ending the L-th EXEC cycle:
    - res<=ula_res and zero<=ula_zero.
    - done_owner<=1.
    - Go to DONE.
  - Requester inputs are ignored; they may change freely after gnt.
- DONE:
  - Lasts one cycle; done_owner is high for that cycle only.
  - Next state is always IDLE; done clears on leaving DONE.
  - res/zero hold until the next capture.
- Timing:
  - For a request sampled at edge k: gnt is high in cycle k+1 and done in cycle k+1+L.
  - Back-to-back throughput is one op per L+2 cycles.
  - A req still high in IDLE after its done counts as a new request.
- Boundary conditions:
  - Opcodes the ULA does not recognise are passed through unchanged.
  - Captured values are whatever the ULA returns (0/0 for default).
  - Zero is forwarded unmodified for all opcodes, including JUMP/JR (Zero=1) and BEQ/BNE.
  - At most one of gnt_0/gnt_1 and at most one of done_0/done_1 is high in any cycle.
  - busy=1 in EXEC and DONE.
- Reset mid-operation (EXEC or DONE):
  - The operation is dropped; no done pulse is issued.
  - The requester must re-request.

Test Plan:
- ADD, LAT_FAST=1: req_0 at edge 0 with op=0, funct=0, a=5, b=7 -> gnt_0 in cycle 1; done_0 in cycle 2 with res=12, zero=0; busy in cycles 1-2.
- MULT, LAT_SLOW=4: req_1 with op=0, funct=2, a=6, b=7 -> gnt_1 in cycle 1; done_1 in cycle 5 with res=42; ula_a/ula_b stable in cycles 1-4 while a_1/b_1 are randomised.
- Tie after reset: req_0 and req_1 both high and held -> grant to 0, then 1, then 0; done pulses never overlap; each result matches its owner's operands (SUB 10-3=7; AND 0xF0&0x3C=0x30).
- BEQ and JUMP: op=0x0A, a=b=9 -> zero=1, res=0. op=0x0A, a=9, b=8 -> zero=0. op=0x05, b=0x40 -> res=0x40, zero=1.
- Mid-op reset: DIV 100/5 on port 0, reset asserted in the 2nd EXEC cycle -> no done_0; all outputs 0 next cycle. A subsequent req_1 and req_0 tie grants port 0; DIV completes with res=20.
